// File: rtl/amba_axi_pkg.sv
// Shared AXI4 types for the DMA read path, plus the DMA beat/descriptor helpers.
package amba_axi_pkg;
   localparam int AXI_ADDR_WIDTH    = 32;
   localparam int AXI_DATA_WIDTH    = 256;
   localparam int AXI_ID_WIDTH      = 4;
   localparam int AXI_USER_WIDTH    = 1;
   localparam int AXI_MAX_OUTSTD_RD = 2;

   typedef logic [AXI_ADDR_WIDTH-1:0] axi_addr_t;
   typedef logic [AXI_DATA_WIDTH-1:0] axi_data_t;
   typedef logic [AXI_ID_WIDTH-1:0]   axi_id_t;
   typedef logic [AXI_USER_WIDTH-1:0] axi_user_t;
   typedef logic [7:0]                axi_len_t;

   typedef enum logic [2:0] {
      AXI_BYTES_1, AXI_BYTES_2, AXI_BYTES_4, AXI_BYTES_8,
      AXI_BYTES_16, AXI_BYTES_32, AXI_BYTES_64, AXI_BYTES_128
   } axi_size_t;
   typedef enum logic [1:0] {AXI_FIXED, AXI_INCR, AXI_WRAP} axi_burst_t;
   typedef enum logic [1:0] {AXI_OKAY, AXI_EXOKAY, AXI_SLVERR, AXI_DECERR} axi_resp_t;

   typedef struct packed {
      axi_id_t                     awid;
      axi_addr_t                   awaddr;
      axi_len_t                    awlen;
      axi_size_t                   awsize;
      axi_burst_t                  awburst;
      logic                        awlock;
      logic [3:0]                  awcache;
      logic [2:0]                  awprot;
      logic [3:0]                  awqos;
      logic [3:0]                  awregion;
      axi_user_t                   awuser;
      logic                        awvalid;
      axi_data_t                   wdata;
      logic [AXI_DATA_WIDTH/8-1:0] wstrb;
      logic                        wlast;
      axi_user_t                   wuser;
      logic                        wvalid;
      logic                        bready;
      axi_id_t                     arid;
      axi_addr_t                   araddr;
      axi_len_t                    arlen;
      axi_size_t                   arsize;
      axi_burst_t                  arburst;
      logic                        arlock;
      logic [3:0]                  arcache;
      logic [2:0]                  arprot;
      logic [3:0]                  arqos;
      logic [3:0]                  arregion;
      axi_user_t                   aruser;
      logic                        arvalid;
      logic                        rready;
   } s_axi_mosi_t;

   typedef struct packed {
      logic       awready;
      logic       wready;
      axi_id_t    bid;
      axi_resp_t  bresp;
      axi_user_t  buser;
      logic       bvalid;
      logic       arready;
      axi_id_t    rid;
      axi_data_t  rdata;
      axi_resp_t  rresp;
      logic       rlast;
      axi_user_t  ruser;
      logic       rvalid;
   } s_axi_miso_t;

   localparam int DMA_BYTES_PER_BEAT = AXI_DATA_WIDTH / 8;
   localparam int DMA_BEATS_PER_4K   = 4096 / DMA_BYTES_PER_BEAT;
   localparam int DMA_BEATS_W        = 16;

   typedef struct packed {
      axi_addr_t              addr;
      logic [DMA_BEATS_W-1:0] beats;
   } s_dma_rd_desc_t;
endpackage

// File: rtl/dma_rd_fifo.sv
// Read-data buffer for the DMA read streamer: registered synchronous FIFO with
// a free-slot count used for AR reservation.
module dma_rd_fifo #(
   parameter int WIDTH = 257,
   parameter int DEPTH = 32
) (
   input  logic                       aclk,
   input  logic                       arst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] free
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push, do_pop;

   assign do_pop  = pop && (count != '0);
   // a pop in the same cycle makes room, so push on full is accepted then
   assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge aclk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];
   assign empty    = (count == '0);
   assign free     = CNT_W'(DEPTH) - count;
endmodule

// File: rtl/dma_axi_rd_streamer.sv
// AXI4 read-master front end of the DMA: splits a descriptor into 4 KB-safe INCR bursts
// and streams returned beats. DMA_RD_ERR_ABORT_EN: stop issuing and discard data on first error.
//
// state   | meaning
// IDLE    | waiting for a descriptor (desc_ready = 1)
// RUN     | issuing ARs and receiving R beats until the descriptor is fully received
module dma_axi_rd_streamer
   import amba_axi_pkg::*;
#(
   parameter int MAX_BURST_BEATS = 16,
   parameter int FIFO_DEPTH      = 32,
   parameter int BEATS_W         = 16
) (
   input  logic               aclk,
   input  logic               arst,
   input  logic               desc_valid,
   output logic               desc_ready,
   input  axi_addr_t          desc_addr,
   input  logic [BEATS_W-1:0] desc_beats,
   output s_axi_mosi_t        axi_mosi_o,
   input  s_axi_miso_t        axi_miso_i,
   output logic               out_valid,
   output axi_data_t          out_data,
   output logic               out_last,
   input  logic               out_ready,
   output logic               done,
   output logic               err
);
   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   localparam int OUTSTD_W = $clog2(AXI_MAX_OUTSTD_RD + 1);
   localparam int FREE_W   = $clog2(FIFO_DEPTH + 1);
   localparam int BEAT_LSB = $clog2(DMA_BYTES_PER_BEAT);
   localparam logic [8:0]          MAX_LEN    = 9'(MAX_BURST_BEATS);
   localparam logic [OUTSTD_W-1:0] MAX_OUTSTD = OUTSTD_W'(AXI_MAX_OUTSTD_RD);

`ifdef DMA_RD_ERR_ABORT_EN
   localparam logic ABORT_EN = 1'b1;
`else
   localparam logic ABORT_EN = 1'b0;
`endif

   logic               state;
   axi_addr_t          addr, ar_addr;
   axi_len_t           ar_len;
   logic               arvalid, aborted;
   logic [BEATS_W-1:0] to_issue, to_recv;
   logic [OUTSTD_W-1:0] outstd;
   logic [FREE_W-1:0]  reserved, free, avail;
   logic [8:0]         bnd_beats, cap, len, ar_beats;
   logic               rready, ar_hs, r_hs, r_err, ar_start, finish, push, fifo_empty;
   logic               unused_inputs;

   assign bnd_beats = 9'(DMA_BEATS_PER_4K) - 9'(addr[11:BEAT_LSB]);
   assign cap       = (bnd_beats < MAX_LEN) ? bnd_beats : MAX_LEN;
   assign len       = (32'(to_issue) < 32'(cap)) ? 9'(to_issue) : cap;
   assign avail     = free - reserved;
   assign ar_beats  = 9'(ar_len) + 9'd1;

   assign desc_ready = (state == ST_IDLE);
   assign rready     = (state == ST_RUN);
   assign ar_hs      = arvalid && axi_miso_i.arready;
   assign r_hs       = axi_miso_i.rvalid && rready;
   assign r_err      = r_hs && (axi_miso_i.rresp != AXI_OKAY);
   assign push       = r_hs && !aborted && !(ABORT_EN && r_err);

   // a burst only goes out once the FIFO can absorb every beat of it
   assign ar_start = (state == ST_RUN) && !arvalid && (to_issue != '0) &&
                     (outstd < MAX_OUTSTD) && (32'(avail) >= 32'(len)) &&
                     !(ABORT_EN && r_err);
   assign finish   = (state == ST_RUN) && (outstd == '0) && !arvalid &&
                     ((to_recv == '0) || aborted);

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         state    <= ST_IDLE;
         addr     <= '0;
         ar_addr  <= '0;
         ar_len   <= '0;
         arvalid  <= 1'b0;
         to_issue <= '0;
         to_recv  <= '0;
         err      <= 1'b0;
         aborted  <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (desc_valid) begin
                  state    <= ST_RUN;
                  addr     <= {desc_addr[AXI_ADDR_WIDTH-1:BEAT_LSB], BEAT_LSB'(0)};
                  to_issue <= desc_beats;
                  to_recv  <= desc_beats;
                  err      <= 1'b0;
                  aborted  <= 1'b0;
               end
            end
            default: begin
               if (ar_start) begin
                  arvalid <= 1'b1;
                  ar_addr <= addr;
                  ar_len  <= 8'(len - 9'd1);
               end else if (ar_hs) begin
                  arvalid <= 1'b0;
               end
               if (ar_hs) begin
                  addr     <= addr + (AXI_ADDR_WIDTH'(ar_beats) << BEAT_LSB);
                  to_issue <= to_issue - BEATS_W'(ar_beats);
               end
               if (r_hs) to_recv <= to_recv - BEATS_W'(1);
               if (r_err) begin
                  err <= 1'b1;
                  if (ABORT_EN) begin
                     aborted  <= 1'b1;
                     to_issue <= '0;
                  end
               end
               if (finish) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         outstd   <= '0;
         reserved <= '0;
      end else begin
         outstd   <= outstd + OUTSTD_W'(ar_hs) - OUTSTD_W'(r_hs && axi_miso_i.rlast);
         reserved <= reserved + (ar_hs ? FREE_W'(ar_beats) : FREE_W'(0)) - FREE_W'(r_hs);
      end
   end

   dma_rd_fifo #(
      .WIDTH (AXI_DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .aclk      (aclk),
      .arst      (arst),
      .push      (push),
      .push_data ({(to_recv == BEATS_W'(1)), axi_miso_i.rdata}),
      .pop       (out_valid && out_ready),
      .pop_data  ({out_last, out_data}),
      .empty     (fifo_empty),
      .free      (free)
   );

   assign out_valid = !fifo_empty;

   always_comb begin
      axi_mosi_o         = '0;
      axi_mosi_o.araddr  = ar_addr;
      axi_mosi_o.arlen   = ar_len;
      axi_mosi_o.arsize  = AXI_BYTES_32;
      axi_mosi_o.arburst = AXI_INCR;
      axi_mosi_o.arvalid = arvalid;
      axi_mosi_o.rready  = rready;
   end

   assign unused_inputs = ^{desc_addr[BEAT_LSB-1:0], axi_miso_i.awready, axi_miso_i.wready,
                            axi_miso_i.bid, axi_miso_i.bresp, axi_miso_i.buser,
                            axi_miso_i.bvalid, axi_miso_i.rid, axi_miso_i.ruser};
endmodule

// File: tb/tb_dma_axi_rd_streamer.sv
// Directed bench for dma_axi_rd_streamer with a 1-cycle-latency AXI read slave model.
module tb_dma_axi_rd_streamer;
   import amba_axi_pkg::*;

   logic        aclk = 1'b0;
   logic        arst;
   logic        desc_valid;
   logic        desc_ready;
   axi_addr_t   desc_addr;
   logic [15:0] desc_beats;
   s_axi_mosi_t mosi;
   s_axi_miso_t miso;
   logic        out_valid;
   axi_data_t   out_data;
   logic        out_last;
   logic        out_ready;
   logic        done;
   logic        err;

   int tests_run = 0;
   int tests_failed = 0;

   logic        ar_ready_ctl, out_ready_ctl, err_en;
   logic [31:0] err_addr;
   int          done_cnt = 0;
   int          cyc = 0;
   logic [31:0] ar_log_addr[$];
   logic [7:0]  ar_log_len[$];
   logic [31:0] exp_addr_q[$];
   logic        exp_last_q[$];
   logic [31:0] bq_addr[$];
   int          bq_len[$];
   int          bq_rdy[$];

   always #5 aclk = ~aclk;

   dma_axi_rd_streamer #(
      .MAX_BURST_BEATS (16),
      .FIFO_DEPTH      (32),
      .BEATS_W         (16)
   ) dut (
      .aclk       (aclk),
      .arst       (arst),
      .desc_valid (desc_valid),
      .desc_ready (desc_ready),
      .desc_addr  (desc_addr),
      .desc_beats (desc_beats),
      .axi_mosi_o (mosi),
      .axi_miso_i (miso),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .done       (done),
      .err        (err)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge aclk);
      #1;
   endtask

   // Slave + stream monitor: decides at each negedge what handshakes the next posedge makes.
   initial begin : slave_model
      logic [31:0] ba;
      logic        pend;
      logic [31:0] pend_addr;
      logic [7:0]  pend_len;
      int          beat_idx;
      miso = '0;
      out_ready = 1'b0;
      pend = 1'b0;
      pend_addr = '0;
      pend_len = '0;
      beat_idx = 0;
      forever begin
         @(negedge aclk);
         if (arst) begin
            bq_addr.delete();
            bq_len.delete();
            bq_rdy.delete();
            beat_idx = 0;
            pend = 1'b0;
            miso = '0;
            out_ready = 1'b0;
         end else begin
            cyc++;
            if (done) done_cnt++;
            miso.arready = ar_ready_ctl;
            out_ready = out_ready_ctl;
            if (pend) begin
               check("ar_hold_valid", 256'(mosi.arvalid), 256'd1);
               check("ar_hold_addr", 256'(mosi.araddr), 256'(pend_addr));
               check("ar_hold_len", 256'(mosi.arlen), 256'(pend_len));
            end
            pend = mosi.arvalid && !miso.arready;
            pend_addr = mosi.araddr;
            pend_len = mosi.arlen;
            if (mosi.arvalid && miso.arready) begin
               ar_log_addr.push_back(mosi.araddr);
               ar_log_len.push_back(mosi.arlen);
               bq_addr.push_back(mosi.araddr);
               bq_len.push_back(int'(mosi.arlen) + 1);
               bq_rdy.push_back(cyc + 1);
               check("outstd_le2", 256'(bq_addr.size() <= 2), 256'd1);
            end
            miso.rvalid = 1'b0;
            miso.rlast = 1'b0;
            miso.rresp = AXI_OKAY;
            miso.rdata = '0;
            if (bq_addr.size() > 0 && bq_rdy[0] <= cyc) begin
               ba = bq_addr[0] + 32'(beat_idx * 32);
               miso.rvalid = 1'b1;
               miso.rdata = {8{ba}};
               miso.rlast = (beat_idx == bq_len[0] - 1);
               miso.rresp = (err_en && ba == err_addr) ? AXI_SLVERR : AXI_OKAY;
            end
            if (miso.rvalid && mosi.rready) begin
               beat_idx++;
               if (beat_idx == bq_len[0]) begin
                  bq_addr.pop_front();
                  bq_len.pop_front();
                  bq_rdy.pop_front();
                  beat_idx = 0;
               end
            end
            if (out_valid && out_ready) begin
               if (exp_addr_q.size() == 0) begin
                  check("out_unexpected", 256'd1, 256'd0);
               end else begin
                  check("out_data", out_data, {8{exp_addr_q[0]}});
                  check("out_last", 256'(out_last), 256'(exp_last_q[0]));
                  void'(exp_addr_q.pop_front());
                  void'(exp_last_q.pop_front());
               end
            end
         end
      end
   end

   task automatic send_desc(input logic [31:0] a, input int n);
      int b = 0;
      ar_log_addr.delete();
      ar_log_len.delete();
      while (!desc_ready && b < 200) begin tick(); b++; end
      check("desc_ready", 256'(desc_ready), 256'd1);
      desc_valid = 1'b1;
      desc_addr = a;
      desc_beats = 16'(n);
      for (int k = 0; k < n; k++) begin
         exp_addr_q.push_back({a[31:5], 5'd0} + 32'(k * 32));
         exp_last_q.push_back(k == n - 1);
      end
      tick();
      desc_valid = 1'b0;
   endtask

   task automatic wait_done(input int start, input int budget);
      int b = 0;
      while (done_cnt == start && b < budget) begin tick(); b++; end
      check("done_pulse", 256'(done_cnt - start), 256'd1);
   endtask

   task automatic wait_drain(input int budget);
      int b = 0;
      while (exp_addr_q.size() != 0 && b < budget) begin tick(); b++; end
      check("drain_left", 256'(exp_addr_q.size()), 256'd0);
   endtask

   initial begin : stimulus
      int d0;
      arst = 1'b1;
      desc_valid = 1'b0;
      desc_addr = '0;
      desc_beats = '0;
      ar_ready_ctl = 1'b1;
      out_ready_ctl = 1'b1;
      err_en = 1'b0;
      err_addr = '0;
      repeat (3) tick();
      check("rst_desc_ready", 256'(desc_ready), 256'd1);
      check("rst_arvalid", 256'(mosi.arvalid), 256'd0);
      check("rst_rready", 256'(mosi.rready), 256'd0);
      check("rst_out_valid", 256'(out_valid), 256'd0);
      check("rst_done", 256'(done), 256'd0);
      check("rst_err", 256'(err), 256'd0);
      arst = 1'b0;
      tick();

      // 40 beats from 0x1000: 16 + 16 + 8
      d0 = done_cnt;
      send_desc(32'h0000_1000, 40);
      wait_done(d0, 400);
      wait_drain(200);
      repeat (3) tick();
      check("t1_done_once", 256'(done_cnt - d0), 256'd1);
      check("t1_ar_cnt", 256'(ar_log_addr.size()), 256'd3);
      check("t1_ar0", {ar_log_addr[0], ar_log_len[0]}, {32'h1000, 8'd15});
      check("t1_ar1", {ar_log_addr[1], ar_log_len[1]}, {32'h1200, 8'd15});
      check("t1_ar2", {ar_log_addr[2], ar_log_len[2]}, {32'h1400, 8'd7});
      check("t1_err", 256'(err), 256'd0);

      // 4 KB split: 4 beats up to 0x1000, then 6
      d0 = done_cnt;
      send_desc(32'h0000_0F80, 10);
      wait_done(d0, 200);
      wait_drain(200);
      check("t2_ar_cnt", 256'(ar_log_addr.size()), 256'd2);
      check("t2_ar0", {ar_log_addr[0], ar_log_len[0]}, {32'h0F80, 8'd3});
      check("t2_ar1", {ar_log_addr[1], ar_log_len[1]}, {32'h1000, 8'd5});

      // downstream stalled: reservation stops at a full FIFO
      out_ready_ctl = 1'b0;
      d0 = done_cnt;
      send_desc(32'h0000_2000, 64);
      repeat (60) tick();
      check("t3_stall_ar_cnt", 256'(ar_log_addr.size()), 256'd2);
      check("t3_stall_out_valid", 256'(out_valid), 256'd1);
      check("t3_stall_arvalid", 256'(mosi.arvalid), 256'd0);
      out_ready_ctl = 1'b1;
      wait_done(d0, 400);
      wait_drain(200);
      check("t3_ar_cnt", 256'(ar_log_addr.size()), 256'd4);
      check("t3_ar2", {ar_log_addr[2], ar_log_len[2]}, {32'h2400, 8'd15});
      check("t3_ar3", {ar_log_addr[3], ar_log_len[3]}, {32'h2600, 8'd15});

      // arready held low: request must wait with stable fields
      ar_ready_ctl = 1'b0;
      d0 = done_cnt;
      send_desc(32'h0000_4000, 32);
      repeat (5) tick();
      check("t4_arvalid", 256'(mosi.arvalid), 256'd1);
      check("t4_araddr", 256'(mosi.araddr), 256'h4000);
      check("t4_arlen", 256'(mosi.arlen), 256'd15);
      check("t4_arsize", 256'(mosi.arsize), 256'(AXI_BYTES_32));
      check("t4_arburst", 256'(mosi.arburst), 256'(AXI_INCR));
      ar_ready_ctl = 1'b1;
      wait_done(d0, 400);
      wait_drain(200);
      check("t4_ar1", {ar_log_addr[1], ar_log_len[1]}, {32'h4200, 8'd15});

      // SLVERR on the second beat of the first burst
      err_en = 1'b1;
      err_addr = 32'h0000_5020;
      d0 = done_cnt;
      send_desc(32'h0000_5000, 32);
`ifdef DMA_RD_ERR_ABORT_EN
      while (exp_addr_q.size() > 1) begin
         void'(exp_addr_q.pop_back());
         void'(exp_last_q.pop_back());
      end
`endif
      wait_done(d0, 400);
      wait_drain(200);
      repeat (3) tick();
      check("t5_err", 256'(err), 256'd1);
      check("t5_done_once", 256'(done_cnt - d0), 256'd1);
`ifndef DMA_RD_ERR_ABORT_EN
      check("t5_ar_cnt", 256'(ar_log_addr.size()), 256'd2);
`endif
      err_en = 1'b0;

      // zero-beat descriptor clears err, issues nothing, still signals done
      d0 = done_cnt;
      send_desc(32'h0000_6000, 0);
      check("t6_err_cleared", 256'(err), 256'd0);
      wait_done(d0, 20);
      repeat (3) tick();
      check("t6_ar_cnt", 256'(ar_log_addr.size()), 256'd0);
      check("t6_idle", 256'(desc_ready), 256'd1);

      // reset in the middle of a descriptor
      out_ready_ctl = 1'b0;
      send_desc(32'h0000_7000, 32);
      repeat (6) tick();
      check("t7_in_run", 256'(mosi.rready), 256'd1);
      arst = 1'b1;
      tick();
      check("t7_rst_arvalid", 256'(mosi.arvalid), 256'd0);
      check("t7_rst_rready", 256'(mosi.rready), 256'd0);
      check("t7_rst_out_valid", 256'(out_valid), 256'd0);
      check("t7_rst_done", 256'(done), 256'd0);
      check("t7_rst_err", 256'(err), 256'd0);
      exp_addr_q.delete();
      exp_last_q.delete();
      tick();
      arst = 1'b0;
      out_ready_ctl = 1'b1;
      tick();
      d0 = done_cnt;
      send_desc(32'h0000_3000, 1);
      wait_done(d0, 100);
      wait_drain(100);
      check("t7_ar_cnt", 256'(ar_log_addr.size()), 256'd1);
      check("t7_ar0", {ar_log_addr[0], ar_log_len[0]}, {32'h3000, 8'd0});

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
